mod_mul_barrett: RTL and testbench

//  Pipelined modular multiplier: out = (a * b) mod Q, Q = 3329 (Kyber).

---
 rtl/kyber_pkg.sv | 11 +
 rtl/barrett_reduce.sv | 58 +++++
 rtl/mod_mul_barrett.sv | 78 +++++++
 tb/tb_mod_mul_barrett.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants for the NTT butterfly datapath.
package kyber_pkg;

    localparam int KYBER_Q   = 3329;
    localparam int COEF_W    = 12;
    localparam int BARRETT_M = 5039;
    localparam int BARRETT_K = 24;
    localparam int PROD_W    = 2 * COEF_W;
    localparam int RED_W     = 14;

endpackage

// File: rtl/barrett_reduce.sv
// Two-stage Barrett reduction of a 24-bit product modulo KYBER_Q.
// Stage A computes the quotient estimate, stage B subtracts and corrects once.
module barrett_reduce
    import kyber_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] p_in,
    input  logic        v_in,
    output logic [11:0] r_out,
    output logic        v_out
);

    logic [RED_W-1:0] p_lo_d, p_lo_q;
    logic [11:0]      t_d, t_q;
    logic             v2_d, v2_q;
    logic [RED_W-1:0] r;
    logic [11:0]      r_out_d, r_out_q;
    logic             v3_d, v3_q;

    always_comb begin
        p_lo_d  = p_lo_q;
        t_d     = t_q;
        v2_d    = v2_q;
        r_out_d = r_out_q;
        v3_d    = v3_q;
        // Only the low bits are needed: r = p - t*Q lies in [0, 2Q).
        r = 14'(p_lo_q - 14'(t_q) * 14'(KYBER_Q));
        if (en) begin
            p_lo_d  = p_in[RED_W-1:0];
            t_d     = 12'((37'(p_in) * 37'(BARRETT_M)) >> BARRETT_K);
            v2_d    = v_in;
            r_out_d = (r >= 14'(KYBER_Q)) ? 12'(r - 14'(KYBER_Q)) : r[11:0];
            v3_d    = v2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_lo_q  <= '0;
            t_q     <= '0;
            v2_q    <= 1'b0;
            r_out_q <= '0;
            v3_q    <= 1'b0;
        end else begin
            p_lo_q  <= p_lo_d;
            t_q     <= t_d;
            v2_q    <= v2_d;
            r_out_q <= r_out_d;
            v3_q    <= v3_d;
        end
    end

    assign r_out = r_out_q;
    assign v_out = v3_q;

endmodule

// File: rtl/mod_mul_barrett.sv
// Pipelined (a*b) mod 3329 multiplier with a global-stall valid/ready pipeline.
// Stage 1 multiplies here; stages 2-3 live in barrett_reduce.
module mod_mul_barrett
    import kyber_pkg::*;
#(
    parameter int W     = COEF_W,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out,
    output logic [TAG_W-1:0] out_tag
);

    logic              adv;
    logic              v3;
    logic [2*W-1:0]    p_d, p_q;
    logic              v1_d, v1_q;
    logic [TAG_W-1:0]  tag1_d, tag1_q;
    logic [TAG_W-1:0]  tag2_d, tag2_q;
    logic [TAG_W-1:0]  tag3_d, tag3_q;

    // Whole pipeline moves together unless the last stage is stuck.
    assign adv      = !v3 || out_ready;
    assign in_ready = adv;

    always_comb begin
        p_d    = p_q;
        v1_d   = v1_q;
        tag1_d = tag1_q;
        tag2_d = tag2_q;
        tag3_d = tag3_q;
        if (adv) begin
            p_d    = (2*W)'(a) * (2*W)'(b);
            v1_d   = in_valid;
            tag1_d = in_tag;
            tag2_d = tag1_q;
            tag3_d = tag2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q    <= '0;
            v1_q   <= 1'b0;
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
        end else begin
            p_q    <= p_d;
            v1_q   <= v1_d;
            tag1_q <= tag1_d;
            tag2_q <= tag2_d;
            tag3_q <= tag3_d;
        end
    end

    barrett_reduce u_reduce (
        .clk   (clk),
        .rst   (rst),
        .en    (adv),
        .p_in  (p_q),
        .v_in  (v1_q),
        .r_out (out),
        .v_out (v3)
    );

    assign out_valid = v3;
    assign out_tag   = tag3_q;

endmodule

// File: tb/tb_mod_mul_barrett.sv
// Directed and randomized bench for mod_mul_barrett.
module tb_mod_mul_barrett;
    import kyber_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] a;
    logic [11:0] b;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out;
    logic [7:0]  out_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_mul_barrett dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_tag   (out_tag)
    );

    always @(negedge clk) begin
        if (!rst && in_valid && in_ready)
            assert (a < 12'(KYBER_Q) && b < 12'(KYBER_Q))
            else $error("operand precondition violated a=%0d b=%0d", a, b);
    end

    task automatic drive(input logic iv, input logic [11:0] ia,
                         input logic [11:0] ib, input logic [7:0] it,
                         input logic ordy);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        in_tag    = it;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 12'd0, 12'd0, 8'h00, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out !== 12'd0 || out_tag !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b out=%0d tag=%h, want 0/0/00",
                     out_valid, out, out_tag);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        tick();
    endtask

    task automatic test_single();
        int seen;
        int nvalid;
        seen   = -1;
        nvalid = 0;
        drive(1'b1, 12'd17, 12'd196, 8'h01, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL single_in_ready c=%0d: got %b want 1", c, in_ready);
            end
            if (out_valid === 1'b1) begin
                nvalid++;
                if (seen < 0) seen = c;
                checks++;
                if (out !== 12'd3 || out_tag !== 8'h01) begin
                    errors++;
                    $display("FAIL single_value: out=%0d tag=%h want 3/01", out, out_tag);
                end
            end
            tick();
            drive(1'b0, 12'd0, 12'd0, 8'h00, 1'b1);
        end
        checks++;
        if (seen !== 3 || nvalid !== 1) begin
            errors++;
            $display("FAIL single_latency: first=%0d count=%0d want 3/1", seen, nvalid);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] va [3];
        logic [11:0] vb [3];
        logic [11:0] ve [3];
        logic [7:0]  vt [3];
        va = '{12'd3328, 12'd0, 12'd1234};
        vb = '{12'd3328, 12'd3000, 12'd2};
        ve = '{12'd1, 12'd0, 12'd2468};
        vt = '{8'h21, 8'h22, 8'h23};
        for (int c = 0; c < 8; c++) begin
            if (c < 3) drive(1'b1, va[c], vb[c], vt[c], 1'b1);
            else       drive(1'b0, 12'd0, 12'd0, 8'h00, 1'b1);
            @(negedge clk);
            checks++;
            if (c >= 3 && c < 6) begin
                if (out_valid !== 1'b1 || out !== ve[c-3] || out_tag !== vt[c-3]) begin
                    errors++;
                    $display("FAIL b2b_out c=%0d: v=%b out=%0d tag=%h want 1/%0d/%h",
                             c, out_valid, out, out_tag, ve[c-3], vt[c-3]);
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle c=%0d: out_valid=%b want 0", c, out_valid);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [11:0] va [6];
        logic [11:0] vb [6];
        logic [11:0] ve [6];
        logic [7:0]  vt [6];
        logic        ordy;
        logic        held;
        logic [11:0] hout;
        logic [7:0]  htag;
        int idx;
        int nout;
        va = '{12'd5, 12'd100, 12'd3328, 12'd2000, 12'd1665, 12'd1000};
        vb = '{12'd7, 12'd100, 12'd1, 12'd3, 12'd2, 12'd1000};
        ve = '{12'd35, 12'd13, 12'd3328, 12'd2671, 12'd1, 12'd1300};
        vt = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        idx  = 0;
        nout = 0;
        held = 1'b0;
        hout = '0;
        htag = '0;
        for (int c = 0; c < 40 && nout < 6; c++) begin
            ordy = !(c == 4 || c == 5);
            if (idx < 6) drive(1'b1, va[idx], vb[idx], vt[idx], ordy);
            else         drive(1'b0, 12'd0, 12'd0, 8'h00, ordy);
            @(negedge clk);
            checks++;
            if (in_ready !== ordy) begin
                errors++;
                $display("FAIL stall_in_ready c=%0d: got %b want %b", c, in_ready, ordy);
            end
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out !== hout || out_tag !== htag) begin
                    errors++;
                    $display("FAIL stall_hold c=%0d: v=%b out=%0d tag=%h want 1/%0d/%h",
                             c, out_valid, out, out_tag, hout, htag);
                end
            end
            held = 1'b0;
            if (out_valid === 1'b1 && !ordy) begin
                held = 1'b1;
                hout = out;
                htag = out_tag;
            end
            if (out_valid === 1'b1 && ordy) begin
                checks++;
                if (out !== ve[nout] || out_tag !== vt[nout]) begin
                    errors++;
                    $display("FAIL stall_out n=%0d: out=%0d tag=%h want %0d/%h",
                             nout, out, out_tag, ve[nout], vt[nout]);
                end
                nout++;
            end
            if (idx < 6 && in_ready === 1'b1) idx++;
            tick();
        end
        checks++;
        if (nout !== 6) begin
            errors++;
            $display("FAIL stall_count: got %0d results want 6", nout);
        end
        drive(1'b0, 12'd0, 12'd0, 8'h00, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_extra c=%0d: out_valid=%b want 0", c, out_valid);
            end
            tick();
        end
    endtask

    task automatic test_reset_in_flight();
        int seen;
        drive(1'b1, 12'd100, 12'd200, 8'hA1, 1'b1);
        tick();
        drive(1'b1, 12'd300, 12'd400, 8'hA2, 1'b1);
        tick();
        drive(1'b0, 12'd0, 12'd0, 8'h00, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush c=%0d: out_valid=%b want 0", c, out_valid);
            end
            tick();
        end
        seen = -1;
        drive(1'b1, 12'd3, 12'd4, 8'h44, 1'b1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && seen < 0) begin
                seen = c;
                checks++;
                if (out !== 12'd12 || out_tag !== 8'h44) begin
                    errors++;
                    $display("FAIL post_reset_value: out=%0d tag=%h want 12/44", out, out_tag);
                end
            end
            tick();
            drive(1'b0, 12'd0, 12'd0, 8'h00, 1'b1);
        end
        checks++;
        if (seen !== 3) begin
            errors++;
            $display("FAIL post_reset_latency: got %0d want 3", seen);
        end
    endtask

    task automatic test_bubble();
        for (int c = 0; c < 7; c++) begin
            if (c == 0)      drive(1'b1, 12'd10, 12'd10, 8'h11, 1'b1);
            else if (c == 2) drive(1'b1, 12'd2, 12'd3, 8'h22, 1'b1);
            else             drive(1'b0, 12'd0, 12'd0, 8'h00, 1'b1);
            @(negedge clk);
            checks++;
            if (c == 3) begin
                if (out_valid !== 1'b1 || out !== 12'd100 || out_tag !== 8'h11) begin
                    errors++;
                    $display("FAIL bubble_first: v=%b out=%0d tag=%h want 1/100/11",
                             out_valid, out, out_tag);
                end
            end else if (c == 5) begin
                if (out_valid !== 1'b1 || out !== 12'd6 || out_tag !== 8'h22) begin
                    errors++;
                    $display("FAIL bubble_second: v=%b out=%0d tag=%h want 1/6/22",
                             out_valid, out, out_tag);
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL bubble_gap c=%0d: out_valid=%b want 0", c, out_valid);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [19:0] q [$];
        logic [19:0] e;
        logic        iv;
        logic        ordy;
        logic [11:0] ra;
        logic [11:0] rb;
        logic [7:0]  rt;
        int unsigned prod;
        int sent;
        int got;
        sent = 0;
        got  = 0;
        for (int c = 0; c < 60000 && got < 10000; c++) begin
            iv   = (sent < 10000) && ($urandom_range(0, 4) != 0);
            ra   = 12'($urandom_range(0, 3328));
            rb   = 12'($urandom_range(0, 3328));
            rt   = 8'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            drive(iv, ra, rb, rt, ordy);
            @(negedge clk);
            if (out_valid === 1'b1 && ordy) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_unexpected: out=%0d tag=%h with no pending", out, out_tag);
                end else begin
                    e = q.pop_front();
                    if (out !== e[11:0] || out_tag !== e[19:12]) begin
                        errors++;
                        if (errors < 20)
                            $display("FAIL rand_value n=%0d: out=%0d tag=%h want %0d/%h",
                                     got, out, out_tag, e[11:0], e[19:12]);
                    end
                end
                checks++;
                if (!(out < 12'(KYBER_Q))) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL rand_range: out=%0d want < 3329", out);
                end
                got++;
            end
            if (iv && in_ready === 1'b1) begin
                prod = (int'(ra) * int'(rb)) % 3329;
                q.push_back({rt, 12'(prod)});
                sent++;
            end
            tick();
        end
        checks++;
        if (got !== 10000) begin
            errors++;
            $display("FAIL rand_count: got %0d results want 10000", got);
        end
        drive(1'b0, 12'd0, 12'd0, 8'h00, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 12'd0, 12'd0, 8'h00, 1'b1);
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_in_flight();
        test_bubble();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
